// File: rtl/dac_arbiter.sv
// dac_arbiter: two-channel sample arbiter feeding a single DAC.
// Each channel has a one-entry holding register. On every tick one full
// register is granted, either round-robin or with fixed A-over-B priority.
// Ticks that find both registers empty are counted as underruns.
module dac_arbiter #(
    parameter int unsigned            DATA_W   = 12,
    parameter logic [DATA_W-1:0]      MIDSCALE = 12'h800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              prio_mode,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_en,
    output logic              grant_b,
    output logic [7:0]        underrun_cnt
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } chan_t;

    chan_t             last_grant;
    logic              full_a;
    logic              full_b;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;

    logic take_a;
    logic take_b;
    logic sel_a;
    logic sel_b;
    logic underrun;
    logic full_a_nxt;
    logic full_b_nxt;

    assign take_a = a_valid & a_ready;
    assign take_b = b_valid & b_ready;

    // Grant selection: only registers already full at the tick edge compete.
    always_comb begin
        sel_a    = 1'b0;
        sel_b    = 1'b0;
        underrun = 1'b0;
        if (tick) begin
            if (full_a && full_b) begin
                if (prio_mode || (last_grant == GRANT_B)) begin
                    sel_a = 1'b1;
                end else begin
                    sel_b = 1'b1;
                end
            end else if (full_a) begin
                sel_a = 1'b1;
            end else if (full_b) begin
                sel_b = 1'b1;
            end else begin
                underrun = 1'b1;
            end
        end
    end

    // Next full state: a granted register is always full, so it cannot also be taking a sample.
    always_comb begin
        full_a_nxt = full_a;
        full_b_nxt = full_b;
        if (sel_a) begin
            full_a_nxt = 1'b0;
        end else if (take_a) begin
            full_a_nxt = 1'b1;
        end
        if (sel_b) begin
            full_b_nxt = 1'b0;
        end else if (take_b) begin
            full_b_nxt = 1'b1;
        end
    end

    // Holding registers, full flags and registered ready outputs.
    // ready is kept low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_a  <= 1'b0;
            full_b  <= 1'b0;
            hold_a  <= '0;
            hold_b  <= '0;
            a_ready <= 1'b0;
            b_ready <= 1'b0;
        end else begin
            full_a  <= full_a_nxt;
            full_b  <= full_b_nxt;
            a_ready <= ~full_a_nxt;
            b_ready <= ~full_b_nxt;
            if (take_a) begin
                hold_a <= a_data;
            end
            if (take_b) begin
                hold_b <= b_data;
            end
        end
    end

    // DAC output register, load strobe and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_data   <= MIDSCALE;
            dac_en     <= 1'b0;
            grant_b    <= 1'b0;
            last_grant <= GRANT_B;
        end else begin
            dac_en <= sel_a | sel_b;
            if (sel_a) begin
                dac_data   <= hold_a;
                grant_b    <= 1'b0;
                last_grant <= GRANT_A;
            end else if (sel_b) begin
                dac_data   <= hold_b;
                grant_b    <= 1'b1;
                last_grant <= GRANT_B;
            end
        end
    end

    // Saturating count of ticks that found no sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dac_arbiter.sv
// Directed self-checking bench for dac_arbiter.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_dac_arbiter;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        prio_mode;
    logic        a_valid;
    logic [11:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [11:0] b_data;
    logic        b_ready;
    logic [11:0] dac_data;
    logic        dac_en;
    logic        grant_b;
    logic [7:0]  underrun_cnt;

    int unsigned vectors;
    int unsigned miscompares;

    dac_arbiter #(.DATA_W(12), .MIDSCALE(12'h800)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .prio_mode    (prio_mode),
        .a_valid      (a_valid),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .dac_data     (dac_data),
        .dac_en       (dac_en),
        .grant_b      (grant_b),
        .underrun_cnt (underrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic va, input logic [11:0] da,
                        input logic vb, input logic [11:0] db);
        a_valid = va;
        a_data  = da;
        b_valid = vb;
        b_data  = db;
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        tick    = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        tick      = 1'b0;
        prio_mode = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_data    = '0;
        b_data    = '0;
        step();
        step();
        vectors++;
        if (dac_data !== 12'h800) begin
            miscompares++;
            $display("FAIL reset_dac_data: got %h expected 800", dac_data);
        end
        vectors++;
        if (dac_en !== 1'b0 || grant_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_en_grant: got en=%b grant_b=%b expected 0 0", dac_en, grant_b);
        end
        vectors++;
        if (underrun_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_underrun: got %0d expected 0", underrun_cnt);
        end
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low: got a=%b b=%b expected 0 0", a_ready, b_ready);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: got a=%b b=%b expected 1 1", a_ready, b_ready);
        end
    endtask

    task automatic test_a_only();
        push(1'b1, 12'd4000, 1'b0, 12'd0);
        vectors++;
        if (a_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL a_only_full: got a_ready=%b expected 0", a_ready);
        end
        // offer different data while the register is full: must be ignored
        push(1'b1, 12'd99, 1'b0, 12'd0);
        do_tick();
        vectors++;
        if (dac_en !== 1'b1 || dac_data !== 12'd4000 || grant_b !== 1'b0) begin
            miscompares++;
            $display("FAIL a_only_grant: got en=%b data=%0d grant_b=%b expected 1 4000 0",
                     dac_en, dac_data, grant_b);
        end
        vectors++;
        if (a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL a_only_ready: got %b expected 1", a_ready);
        end
        step();
        vectors++;
        if (dac_en !== 1'b0 || dac_data !== 12'd4000) begin
            miscompares++;
            $display("FAIL a_only_strobe: got en=%b data=%0d expected 0 4000", dac_en, dac_data);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        prio_mode = 1'b0;
        push(1'b1, 12'd1000, 1'b1, 12'd500);
        do_tick();
        vectors++;
        if (dac_en !== 1'b1 || dac_data !== 12'd1000 || grant_b !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_first: got en=%b data=%0d grant_b=%b expected 1 1000 0",
                     dac_en, dac_data, grant_b);
        end
        vectors++;
        if (b_ready !== 1'b0 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rr_ready: got a=%b b=%b expected 1 0", a_ready, b_ready);
        end
        push(1'b1, 12'd1234, 1'b0, 12'd0);
        do_tick();
        vectors++;
        if (dac_en !== 1'b1 || dac_data !== 12'd500 || grant_b !== 1'b1) begin
            miscompares++;
            $display("FAIL rr_second: got en=%b data=%0d grant_b=%b expected 1 500 1",
                     dac_en, dac_data, grant_b);
        end
        do_tick();
        vectors++;
        if (dac_en !== 1'b1 || dac_data !== 12'd1234 || grant_b !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_third: got en=%b data=%0d grant_b=%b expected 1 1234 0",
                     dac_en, dac_data, grant_b);
        end
        vectors++;
        if (underrun_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL rr_underrun: got %0d expected 0", underrun_cnt);
        end
    endtask

    task automatic test_fixed_priority();
        prio_mode = 1'b1;
        push(1'b1, 12'd100, 1'b1, 12'd777);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            vectors++;
            if (dac_en !== 1'b1 || grant_b !== 1'b0 || dac_data !== 12'(100 + i)) begin
                miscompares++;
                $display("FAIL fixed_grant_%0d: got en=%b grant_b=%b data=%0d expected 1 0 %0d",
                         i, dac_en, grant_b, dac_data, 100 + i);
            end
            vectors++;
            if (b_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL fixed_b_held_%0d: got b_ready=%b expected 0", i, b_ready);
            end
            push(1'b1, 12'(101 + i), 1'b0, 12'd0);
        end
        // switch to round-robin: last grant was A, so B wins the contended tick
        prio_mode = 1'b0;
        do_tick();
        vectors++;
        if (dac_en !== 1'b1 || grant_b !== 1'b1 || dac_data !== 12'd777) begin
            miscompares++;
            $display("FAIL mode_switch: got en=%b grant_b=%b data=%0d expected 1 1 777",
                     dac_en, grant_b, dac_data);
        end
        do_tick();
        vectors++;
        if (dac_en !== 1'b1 || grant_b !== 1'b0 || dac_data !== 12'd103) begin
            miscompares++;
            $display("FAIL mode_drain: got en=%b grant_b=%b data=%0d expected 1 0 103",
                     dac_en, grant_b, dac_data);
        end
    endtask

    task automatic test_underrun();
        apply_reset();
        push(1'b1, 12'd321, 1'b0, 12'd0);
        do_tick();
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (underrun_cnt !== 8'd0 || dac_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_tick: got cnt=%0d en=%b expected 0 0", underrun_cnt, dac_en);
        end
        for (int i = 0; i < 300; i++) begin
            do_tick();
            vectors++;
            if (dac_en !== 1'b0) begin
                miscompares++;
                $display("FAIL underrun_en_%0d: got %b expected 0", i, dac_en);
            end
            if (i == 0) begin
                vectors++;
                if (underrun_cnt !== 8'd1) begin
                    miscompares++;
                    $display("FAIL underrun_first: got %0d expected 1", underrun_cnt);
                end
            end
            if (i == 254) begin
                vectors++;
                if (underrun_cnt !== 8'd255) begin
                    miscompares++;
                    $display("FAIL underrun_reach_max: got %0d expected 255", underrun_cnt);
                end
            end
            step();
        end
        vectors++;
        if (underrun_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL underrun_saturate: got %0d expected 255", underrun_cnt);
        end
        vectors++;
        if (dac_data !== 12'd321 || grant_b !== 1'b0) begin
            miscompares++;
            $display("FAIL underrun_hold: got data=%0d grant_b=%b expected 321 0", dac_data, grant_b);
        end
    endtask

    task automatic test_corners();
        apply_reset();
        // transfer on the same edge as a tick is not eligible for that tick
        a_valid = 1'b1;
        a_data  = 12'd55;
        tick    = 1'b1;
        step();
        a_valid = 1'b0;
        tick    = 1'b0;
        vectors++;
        if (dac_en !== 1'b0 || underrun_cnt !== 8'd1 || a_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL coincident_xfer: got en=%b cnt=%0d a_ready=%b expected 0 1 0",
                     dac_en, underrun_cnt, a_ready);
        end
        do_tick();
        vectors++;
        if (dac_en !== 1'b1 || dac_data !== 12'd55 || grant_b !== 1'b0) begin
            miscompares++;
            $display("FAIL coincident_next: got en=%b data=%0d grant_b=%b expected 1 55 0",
                     dac_en, dac_data, grant_b);
        end
        // reset pulse while both registers are full, with a coincident tick
        push(1'b1, 12'd11, 1'b1, 12'd22);
        rst_n = 1'b0;
        tick  = 1'b1;
        step();
        tick = 1'b0;
        vectors++;
        if (dac_en !== 1'b0 || dac_data !== 12'h800 || underrun_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL midrun_reset: got en=%b data=%h cnt=%0d expected 0 800 0",
                     dac_en, dac_data, underrun_cnt);
        end
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset_ready: got a=%b b=%b expected 0 0", a_ready, b_ready);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_release: got a=%b b=%b expected 1 1", a_ready, b_ready);
        end
        do_tick();
        vectors++;
        if (dac_en !== 1'b0 || underrun_cnt !== 8'd1 || dac_data !== 12'h800) begin
            miscompares++;
            $display("FAIL discarded: got en=%b cnt=%0d data=%h expected 0 1 800",
                     dac_en, underrun_cnt, dac_data);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        tick        = 1'b0;
        prio_mode   = 1'b0;
        a_valid     = 1'b0;
        b_valid     = 1'b0;
        a_data      = '0;
        b_data      = '0;
        step();
        test_reset();
        test_a_only();
        test_round_robin();
        test_fixed_priority();
        test_underrun();
        test_corners();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
